// File: rtl/cache_pkg.sv
// Shared types for the cache request queue: FSM state encoding and the
// request record that travels through the FIFO.
package cache_pkg;

    localparam int WIDTH       = 8;
    localparam int RAM_DEPTH   = 256;
    localparam int ADDR_W      = $clog2(RAM_DEPTH);
    localparam int DEF_QDEPTH  = 4;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } req_t;

endpackage

// File: rtl/cache_req_queue_if.sv
// Client request/response and cache-side signals of the request queue.
// Handshake: a request transfers on any clk edge where req_valid && req_ready;
// rsp_valid is a one-cycle pulse with no back-pressure, rsp_* valid only with it.
interface cache_req_queue_if;
    import cache_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_data;
    logic              rsp_valid;
    logic              rsp_we;
    logic [ADDR_W-1:0] rsp_addr;
    logic [WIDTH-1:0]  rsp_data;
    logic              rsp_err;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data_in;
    logic              done;
    logic              op_in_progress;
    logic [WIDTH-1:0]  data_out;

    modport slave (
        input  req_valid, req_we, req_addr, req_data, done, op_in_progress, data_out,
        output req_ready, rsp_valid, rsp_we, rsp_addr, rsp_data, rsp_err,
               we, re, addr, data_in
    );

    modport master (
        output req_valid, req_we, req_addr, req_data, done, op_in_progress, data_out,
        input  req_ready, rsp_valid, rsp_we, rsp_addr, rsp_data, rsp_err,
               we, re, addr, data_in
    );

endinterface

// File: rtl/req_fifo.sv
// Synchronous FIFO, power-of-two depth, with a combinational head view.
// Push when full and pop when empty are ignored.
module req_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DW-1:0]          push_data_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PW'(1);
        if (do_pop)  rd_d = rd_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/cache_req_queue.sv
// Request stage in front of the cache: queues client requests, issues them one
// at a time as we/re pulses, waits for done (or a watchdog), returns a response.
module cache_req_queue
    import cache_pkg::*;
#(
    parameter int QDEPTH  = DEF_QDEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    cache_req_queue_if.slave        bus,
    output state_t                  dbg_state_o,
    output logic [$clog2(QDEPTH):0] dbg_count_o
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    req_t              cur_q, cur_d;
    req_t              push_req, head;
    logic              we_q, we_d, re_q, re_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d;
    logic [WIDTH-1:0]  din_q, din_d, rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
    logic              fifo_full, fifo_empty, pop;

    assign push_req = '{we: bus.req_we, addr: bus.req_addr, data: bus.req_data};

    req_fifo #(
        .DW    ($bits(req_t)),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.req_valid),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (dbg_count_o)
    );

    // Outputs are registered, so each transition loads the values seen in the next state.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cur_d       = cur_q;
        pop         = 1'b0;
        we_d        = 1'b0;
        re_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = rsp_we_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.op_in_progress) begin
                    pop     = 1'b1;
                    cur_d   = head;
                    we_d    = head.we;
                    re_d    = !head.we;
                    addr_d  = head.addr;
                    din_d   = head.data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done takes priority over an expiring watchdog on the same cycle.
                if (bus.done || tmo_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = cur_q.we;
                    rsp_addr_d  = cur_q.addr;
                    rsp_err_d   = !bus.done;
                    rsp_data_d  = (bus.done && !cur_q.we) ? bus.data_out : '0;
                    state_d     = RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            tmo_q       <= '0;
            cur_q       <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cur_q       <= cur_d;
            we_q        <= we_d;
            re_q        <= re_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.we        = we_q;
    assign bus.re        = re_q;
    assign bus.addr      = addr_q;
    assign bus.data_in   = din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cache_req_queue.sv
// Bench for cache_req_queue: a behavioural cache with a per-request plan,
// an in-order response scoreboard and directed plus random request streams.
module tb_cache_req_queue;
    import cache_pkg::*;

    localparam int QD = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    state_t     dbg_state;
    logic [2:0] dbg_count;

    always #5 clk = ~clk;

    cache_req_queue_if bus ();

    cache_req_queue #(
        .QDEPTH  (QD),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state),
        .dbg_count_o (dbg_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int rsp_cnt = 0;
    int last_issue_cyc = 0;

    // exp_q entry: {we, addr, data, err}; plan_q entry: {we, addr, data, hung, delay}
    logic [17:0] exp_q[$];
    logic [20:0] plan_q[$];
    logic [7:0]  model_mem[256];
    logic [7:0]  cache_mem[256];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: responses follow acceptance order; a hung request returns err with data 0
    // and never commits its write.
    function automatic void model_accept(input logic we, input logic [7:0] a, input logic [7:0] d,
                                         input logic hung, input logic [2:0] dly);
        logic [7:0] rd;
        rd = (hung || we) ? 8'h00 : model_mem[a];
        if (we && !hung) model_mem[a] = d;
        exp_q.push_back({we, a, rd, hung});
        plan_q.push_back({we, a, d, hung, dly});
    endfunction

    task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic hung, input logic [2:0] dly, output int waited);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_data  = d;
        while (bus.req_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL push_accept actual=req_ready_low expected=accepted addr=%0h", a);
        end else begin
            model_accept(we, a, d, hung, dly);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Behavioural cache: done after the planned delay, or a late done for hung requests.
    initial begin
        int done_cnt, late_cnt;
        logic [20:0] p;
        logic cur_we;
        logic [7:0] cur_addr, cur_data;
        done_cnt = 0;
        late_cnt = 0;
        cur_we = 1'b0;
        cur_addr = '0;
        cur_data = '0;
        bus.done = 1'b0;
        bus.data_out = '0;
        forever begin
            @(negedge clk);
            bus.done = 1'b0;
            bus.data_out = 8'($urandom);
            if (!rst) begin
                done_cnt = 0;
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    bus.done = 1'b1;
                    if (cur_we) cache_mem[cur_addr] = cur_data;
                    else bus.data_out = cache_mem[cur_addr];
                end
            end
            if (late_cnt > 0) begin
                late_cnt--;
                if (late_cnt == 0) bus.done = 1'b1;
            end
            if (bus.we === 1'b1 || bus.re === 1'b1) begin
                issue_cnt++;
                chk("we_re_exclusive", {31'd0, bus.we & bus.re}, 0);
                if (plan_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue actual=we%0b_re%0b expected=no_issue addr=%0h",
                             bus.we, bus.re, bus.addr);
                end else begin
                    p = plan_q.pop_front();
                    chk("issue_we", {31'd0, bus.we}, {31'd0, p[20]});
                    chk("issue_re", {31'd0, bus.re}, {31'd0, !p[20]});
                    chk("issue_addr", {24'd0, bus.addr}, {24'd0, p[19:12]});
                    chk("issue_data_in", {24'd0, bus.data_in}, {24'd0, p[11:4]});
                    cur_we = p[20];
                    cur_addr = p[19:12];
                    cur_data = p[11:4];
                    last_issue_cyc = cyc;
                    if (p[3]) late_cnt = TO + 2;
                    else done_cnt = int'(p[2:0]);
                end
            end
        end
    end

    // Response monitor: every rsp_valid pulse must match the oldest expected response.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=rsp_addr_%0h expected=no_response", bus.rsp_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_we", {31'd0, bus.rsp_we}, {31'd0, e[17]});
                    chk("rsp_addr", {24'd0, bus.rsp_addr}, {24'd0, e[16:9]});
                    chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e[8:1]});
                    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[0]});
                    if (e[0]) chk("timeout_latency", cyc - last_issue_cyc, TO + 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int w, base, before_rsp, before_iss, n;
        logic we;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.op_in_progress = 1'b0;
        for (int i = 0; i < 256; i++) begin
            cache_mem[i] = 8'($urandom);
            model_mem[i] = cache_mem[i];
        end

        // Reset and idle
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("reset_ctrl", {27'd0, bus.we, bus.re, bus.rsp_valid, bus.rsp_we, bus.rsp_err}, 0);
        chk("reset_bus", {bus.addr, bus.data_in, bus.rsp_addr, bus.rsp_data}, 0);
        chk("reset_req_ready", {31'd0, bus.req_ready}, 1);
        chk("reset_count", {29'd0, dbg_count}, 0);
        repeat (20) @(negedge clk);
        chk("idle_no_issue", issue_cnt, 0);

        // Single write then read of the same location
        push(1'b1, 8'h10, 8'hA5, 1'b0, 3'd2, w);
        push(1'b0, 8'h10, 8'h00, 1'b0, 3'd1, w);
        wait_drain();

        // FIFO full with the cache held busy
        bus.op_in_progress = 1'b1;
        base = issue_cnt;
        for (int i = 0; i < 4; i++) begin
            we = 1'($urandom_range(0, 1));
            push(we, 8'(8'h20 + i), 8'($urandom), 1'b0, 3'($urandom_range(1, 6)), w);
        end
        chk("full_count", {29'd0, dbg_count}, 4);
        chk("full_req_ready", {31'd0, bus.req_ready}, 0);
        chk("full_no_issue", issue_cnt, base);
        bus.op_in_progress = 1'b0;
        push(1'b0, 8'h24, 8'h00, 1'b0, 3'd3, w);
        chk("fifth_waited", {31'd0, w > 0}, 1);
        chk("fifth_after_pop", {31'd0, issue_cnt > base}, 1);
        wait_drain();

        // Simultaneous push and pop at count 3
        bus.op_in_progress = 1'b1;
        for (int i = 1; i <= 3; i++)
            push(1'($urandom_range(0, 1)), 8'(i), 8'($urandom), 1'b0, 3'($urandom_range(1, 6)), w);
        chk("pp_count_before", {29'd0, dbg_count}, 3);
        bus.op_in_progress = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_addr = 8'h04;
        bus.req_data = 8'h00;
        model_accept(1'b0, 8'h04, 8'h00, 1'b0, 3'd2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pp_count_after", {29'd0, dbg_count}, 3);
        for (int i = 5; i <= 8; i++)
            push(1'($urandom_range(0, 1)), 8'(i), 8'($urandom), 1'b0, 3'($urandom_range(1, 6)), w);
        wait_drain();

        // Timeout, then a late done must not produce another response
        push(1'b0, 8'h33, 8'h00, 1'b1, 3'd0, w);
        wait_drain();
        before_rsp = rsp_cnt;
        repeat (10) @(negedge clk);
        chk("late_done_ignored", rsp_cnt, before_rsp);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            push(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
                 ($urandom_range(0, 9) == 0), 3'($urandom_range(1, 6)), w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain();
        repeat (TO + 5) @(negedge clk);

        // Reset while WAIT has two requests queued behind it
        push(1'b0, 8'h40, 8'h00, 1'b1, 3'd0, w);
        push(1'b0, 8'h41, 8'h00, 1'b0, 3'd1, w);
        push(1'b0, 8'h42, 8'h00, 1'b0, 3'd1, w);
        n = 0;
        while (!(dbg_state == WAIT && dbg_count == 3'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midwait_reached", {31'd0, n < 50}, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        plan_q.delete();
        rst = 1'b1;
        before_rsp = rsp_cnt;
        before_iss = issue_cnt;
        chk("post_reset_ready", {31'd0, bus.req_ready}, 1);
        repeat (100) @(negedge clk);
        chk("post_reset_count", {29'd0, dbg_count}, 0);
        chk("post_reset_no_rsp", rsp_cnt, before_rsp);
        chk("post_reset_no_issue", issue_cnt, before_iss);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_req_queue.md
Name: cache_req_queue

Overview:
- Front-end request stage that sits directly upstream of the cache/RAM top level.
- Accepts read/write requests from a client into a small FIFO.
- Issues requests to the cache one at a time as single-cycle we/re pulses, waits for done, and returns a response (read data or write acknowledge).
- Adds a watchdog timeout so a hung cache operation cannot stall the client indefinitely.

Parameters:
- WIDTH, 8, data width; must match the cache/RAM data width.
- RAM_DEPTH, 256, address space; address width is $clog2(RAM_DEPTH).
- QDEPTH, 4, request FIFO entries; must be a power of two and at least 2.
- TIMEOUT, 64, maximum cycles spent in WAIT before an error response is produced.

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  client request strobe
- req_ready  out  1  FIFO can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  $clog2(RAM_DEPTH)  request address
- req_data  in  WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_we  out  1  echoes the request type
- rsp_addr  out  $clog2(RAM_DEPTH)  echoes the request address
- rsp_data  out  WIDTH  read data; 0 for writes and for errors
- rsp_err  out  1  timeout flag, valid with rsp_valid
- we  out  1  cache write pulse
- re  out  1  cache read pulse
- addr  out  $clog2(RAM_DEPTH)  cache address
- data_in  out  WIDTH  cache write data
- done  in  1  cache completion, one-cycle pulse
- op_in_progress  in  1  cache busy
- data_out  in  WIDTH  cache read data, valid when done=1

Behaviour:
- Reset (rst=0 at a clk edge):
  - FIFO is emptied: pointers and count go to 0.
  - FSM goes to IDLE and the timeout counter clears.
  - All outputs are 0, except req_ready, which is 1 in the first cycle after reset.
  - Reset mid-operation drops the queued and in-flight requests; no response is ever produced for them.
- FIFO:
  - Push when req_valid && req_ready.
  - req_ready = (count != QDEPTH); it is combinational from registered count.
  - Push and pop in the same cycle leaves count unchanged and is legal at any fill level except push-when-full, which req_ready prevents.
  - Pointers wrap modulo QDEPTH.
- FSM states:
  - IDLE: if FIFO is non-empty and op_in_progress=0, pop the head into the current-request register and go to ISSUE. Otherwise stay.
  - ISSUE (exactly one cycle):
    - Drive we=cur_we and re=!cur_we, with addr and data_in from the current request.
    - we and re are never both 1.
    - Clear the timeout counter and go to WAIT.
  - WAIT: we=re=0; addr and data_in hold their values.
    - If done=1: capture data_out (reads only; writes capture 0) and go to RESP.
    - Else if counter == TIMEOUT-1: set the error flag and go to RESP.
    - Else: increment the counter.
    - If done arrives on the same cycle as the timeout, done wins and no error is flagged.
  - RESP (one cycle): rsp_valid=1 with rsp_we, rsp_addr, rsp_data, rsp_err. Then go to IDLE.
- Latency: minimum 3 cycles from pop to rsp_valid (ISSUE, WAIT with done on its first cycle, RESP).
- Back-to-back requests: the next issue occurs no earlier than the cycle after RESP, and only once op_in_progress=0.
- done while in IDLE, ISSUE, or RESP is ignored. A done arriving after a timeout is ignored.
- Response ordering: responses are returned strictly in request order.
- All outputs are registered except req_ready.

Decomposition:
- Shared package cache_pkg:
  - State enum typedef {IDLE, ISSUE, WAIT, RESP}.
  - Request struct typedef {we, addr, data}, parameterised via localparams ADDR_W = $clog2(RAM_DEPTH).
- Sub-module req_fifo:
  - Parameterised synchronous FIFO with push, pop, full, empty, count, and head-data ports.
  - Same clock and reset convention as this block.
  - Instantiated once.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> all outputs 0, req_ready=1, no we/re pulses for 20 cycles.
- Single write then read:
  - Push write addr=0x10 data=0xA5 -> one we pulse with addr=0x10, data_in=0xA5; after done, rsp_valid with rsp_we=1, rsp_err=0.
  - Push read addr=0x10 with model data_out=0xA5 -> rsp_data=0xA5, rsp_addr=0x10.
- FIFO full: hold op_in_progress=1 and push 5 requests -> req_ready=0 after the 4th. Release -> 4 responses in push order; the 5th push is accepted only after the first pop.
- Simultaneous push/pop at count=3 -> count stays 3; no request is lost or duplicated (scoreboard addresses 0x01..0x08).
- Timeout: withhold done -> rsp_valid with rsp_err=1, rsp_data=0 exactly TIMEOUT+1 cycles after ISSUE. A later done pulse produces no extra response.
- Reset mid-WAIT with 2 queued requests -> no responses appear; count=0; req_ready=1 after release.
